sdram_lfsr_tester: RTL
======================

Name: sdram_lfsr_tester

Overview:
- Sequencer for the SDRAM test project. Owns a 22-bit LFSR (x^22 + x^21 + 1) and uses it to fill a region of memory with pseudo-random data, then rewinds the LFSR and reads the region back to compare.
- Talks to the SDRAM controller through a single req/ack port.
- Reports pass count, error count and the first failing address to the status/LED logic.

Parameters:
- ADDR_WIDTH, 22: word-address width; one pass covers 2^ADDR_WIDTH words, address 0 upward.
- DATA_WIDTH, 16: memory word width, must be <= 22; data word = lfsr[DATA_WIDTH-1:0].
- SEED, 22'd4: LFSR value after reset; must be non-zero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse; starts a run when idle
- stop  in  1  level; finish the current pass, then return to idle
- mem_req  out  1  request to SDRAM controller, held until ack
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_WIDTH  word address; valid while mem_req
- mem_wdata  out  DATA_WIDTH  write data; valid while mem_req && mem_wr
- mem_ack  in  1  1-cycle acknowledge; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  high in any state except IDLE
- pass_count  out  16  completed verify passes, wraps at 0xFFFF -> 0
- error_count  out  16  mismatched words, saturates at 0xFFFF
- error_flag  out  1  sticky; set on the first mismatch
- fail_addr  out  ADDR_WIDTH  address of the first mismatch since start

Behaviour:
- Reset (async, immediate):
  - state = IDLE, lfsr = SEED, saved_seed = SEED.
  - mem_req = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, pass_count = 0, error_count = 0, error_flag = 0, fail_addr = 0.
  - Reset mid-transaction drops mem_req immediately; the memory side must tolerate an abandoned request.
- LFSR step: lfsr <= {lfsr[20:0], lfsr[21]^lfsr[20]}. It advances only on an accepted beat (mem_req && mem_ack); there is no free-running advance.
- States:
  - IDLE:
    - start -> WRITE. Clears pass_count, error_count, error_flag and fail_addr.
    - saved_seed <= lfsr, mem_addr <= 0.
    - start is ignored when not IDLE.
  - WRITE:
    - mem_req = 1, mem_wr = 1, mem_wdata = lfsr[DATA_WIDTH-1:0].
    - On ack: mem_addr++ and the LFSR steps. The next beat is presented the following cycle with mem_req held high (back-to-back allowed).
    - On ack at address 2^ADDR_WIDTH-1 -> REWIND. mem_req drops the next cycle.
  - REWIND (1 cycle):
    - mem_req = 0.
    - next_seed <= lfsr (the post-write value), lfsr <= saved_seed, mem_addr <= 0. Then -> READ.
  - READ:
    - mem_req = 1, mem_wr = 0.
    - On ack: compare mem_rdata with lfsr[DATA_WIDTH-1:0].
      - On mismatch, error_count increments (saturating).
      - On the first mismatch, fail_addr <= mem_addr and error_flag <= 1.
    - Then mem_addr++ and the LFSR steps.
    - On ack at the last address -> NEXT.
  - NEXT (1 cycle):
    - mem_req = 0, pass_count++.
    - lfsr <= next_seed, saved_seed <= next_seed, mem_addr <= 0.
    - stop high -> IDLE, otherwise -> WRITE. Each pass therefore uses fresh data.
- Address counter wraps naturally. The last-beat compare is mem_addr == all-ones.
- mem_addr, mem_wr and mem_wdata change only on ack or on a state change, never while an un-acked request is pending.
- mem_ack with mem_req low is ignored.
- stop is sampled only in NEXT; a pass always completes.
- Error counters update in the ack cycle, so they are visible one cycle after ack.
- Outputs are registered; there is no combinational path from mem_ack to mem_req.

Test Plan:
- Reset, then start, with ADDR_WIDTH = 4 and a memory model that acks immediately:
  - First three writes: addr 0, 1, 2 with data 0x0004, 0x0008, 0x0010.
  - 16 writes, then a 1-cycle mem_req gap, then 16 reads of the same data.
  - pass_count = 1, error_count = 0.
- Memory model corrupts the read at addr 5 (bit 0 flipped):
  - error_flag = 1, error_count = 1, fail_addr = 5 after pass 1.
  - fail_addr stays 5 in later passes even with further errors.
- Ack delayed by a random 0-7 cycles:
  - mem_req, mem_addr and mem_wdata stay stable until ack.
  - Results are identical to the immediate-ack case.
- stop asserted mid-WRITE of pass 2:
  - The pass finishes its reads, then pass_count = 2, state IDLE, busy = 0, mem_req = 0.
  - The pass-2 write seed equals the LFSR value after the pass-1 writes (16 steps from 4).
- Async reset asserted while mem_req = 1 mid-READ:
  - mem_req falls in the same cycle, all status outputs are 0, lfsr = 4.
  - A new start replays data from 0x0004.
- Memory model returns all data wrong for 0x10000 reads (ADDR_WIDTH = 16, multiple passes):
  - error_count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/sdram_lfsr_tester.sv
// SDRAM soak-test sequencer: fills memory from a 22-bit LFSR (x^22 + x^21 + 1),
// rewinds the LFSR and reads the region back, counting passes and mismatches.
module sdram_lfsr_tester #(
  parameter int          ADDR_WIDTH = 22,
  parameter int          DATA_WIDTH = 16,
  parameter logic [21:0] SEED       = 22'd4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [15:0]           pass_count,
  output logic [15:0]           error_count,
  output logic                  error_flag,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    REWIND = 3'd2,
    READ   = 3'd3,
    NEXT   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [21:0] lfsr, lfsr_next;
  logic [21:0] saved_seed;
  logic [21:0] next_seed;
  logic        beat;
  logic        last_addr;
  logic        mismatch;

  function automatic logic [21:0] lfsr_step(input logic [21:0] v);
    return {v[20:0], v[21] ^ v[20]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign beat      = mem_req && mem_ack;
  assign last_addr = (mem_addr == '1);
  assign mismatch  = (state == READ) && beat && (mem_rdata != lfsr[DATA_WIDTH-1:0]);

  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    case (state)
      IDLE:   if (start) state_next = WRITE;
      WRITE: begin
        if (beat) begin
          lfsr_next = lfsr_step(lfsr);
          if (last_addr) state_next = REWIND;
        end
      end
      REWIND: begin
        lfsr_next  = saved_seed;
        state_next = READ;
      end
      READ: begin
        if (beat) begin
          lfsr_next = lfsr_step(lfsr);
          if (last_addr) state_next = NEXT;
        end
      end
      NEXT: begin
        lfsr_next  = next_seed;
        state_next = stop ? IDLE : WRITE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, LFSR and the registered memory port. Everything is
  // derived from state_next so the port is glitch-free and ack never reaches
  // mem_req combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      saved_seed <= SEED;
      next_seed  <= SEED;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state   <= state_next;
      lfsr    <= lfsr_next;
      busy    <= (state_next != IDLE);
      mem_req <= (state_next == WRITE) || (state_next == READ);
      mem_wr  <= (state_next == WRITE);
      // lfsr_next only moves on an accepted beat or a state change, so the
      // write data stays put while a request is outstanding.
      if (state_next == WRITE) mem_wdata <= lfsr_next[DATA_WIDTH-1:0];
      if (state == WRITE || state == READ) begin
        if (beat) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end else begin
        mem_addr <= '0;
      end
      if (state == IDLE)   saved_seed <= lfsr;
      if (state == NEXT)   saved_seed <= next_seed;
      if (state == REWIND) next_seed  <= lfsr;
    end
  end

  // Status counters: cleared by a run start, updated in the ack cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count  <= 16'd0;
      error_count <= 16'd0;
      error_flag  <= 1'b0;
      fail_addr   <= '0;
    end else if (state == IDLE && start) begin
      pass_count  <= 16'd0;
      error_count <= 16'd0;
      error_flag  <= 1'b0;
      fail_addr   <= '0;
    end else begin
      if (state == NEXT) pass_count <= pass_count + 16'd1;
      if (mismatch) begin
        error_count <= sat_inc16(error_count);
        if (!error_flag) begin
          error_flag <= 1'b1;
          fail_addr  <= mem_addr;
        end
      end
    end
  end

endmodule
